// File: rtl/ram_based_fifo_result_packer.sv
// Upsizing result FIFO: packs pairs of narrow writes into one wide RAM entry, read out wide.
// Optional RESULT_PACKER_FLUSH_EN lets i_flush zero-pad a trailing odd half-word.
module ram_based_fifo_result_packer #(
    parameter int DATA_W                 = 64,
    parameter int DEPTH_W                = 9,
    parameter int DATA_R                 = 128,
    parameter int DEPTH_R                = 8,
    parameter int ALMOST_FULL_THRESHOLD  = 480,
    parameter int ALMOST_EMPTY_THRESHOLD = 16
) (
    input  logic              system_clk,
    input  logic              rst,
    input  logic              i_wren,
    input  logic [DATA_W-1:0] i_wrdata,
    output logic              o_full,
    output logic              o_almost_full,
    input  logic              i_rden,
    output logic [DATA_R-1:0] o_rddata,
    output logic              o_rdvalid,
    output logic              o_empty,
    output logic              o_almost_empty,
    input  logic              i_flush
);

    localparam logic [DEPTH_W:0]   CNT_FULL = {1'b1, {DEPTH_W{1'b0}}};
    localparam logic [DEPTH_W:0]   AF_TH    = (DEPTH_W+1)'(ALMOST_FULL_THRESHOLD);
    localparam logic [DEPTH_W-1:0] AE_TH    = DEPTH_W'(ALMOST_EMPTY_THRESHOLD);

    logic [DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_R-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_W:0]   cnt_q, cnt_d;
    logic [DATA_R-1:0]  rddata_q, rddata_d;
    logic               rdvalid_q;

    logic [DATA_R-1:0]  mem_q [2**DEPTH_R];

    logic               wren, rden, flush_acc, half_we;
    logic [DATA_W-1:0]  half_data;

    assign o_full         = (cnt_q == CNT_FULL);
    assign o_empty        = (cnt_q[DEPTH_W:1] == '0);
    assign o_almost_full  = (cnt_q >= AF_TH);
    assign o_almost_empty = (cnt_q[DEPTH_W:1] < AE_TH);

    assign wren = i_wren & ~o_full;
    assign rden = i_rden & ~o_empty;

`ifdef RESULT_PACKER_FLUSH_EN
    // Padding only when a half-word is dangling; an explicit write takes priority.
    assign flush_acc = i_flush & cnt_q[0] & ~i_wren & ~o_full;
`else
    logic unused_flush;
    assign unused_flush = i_flush;
    assign flush_acc    = 1'b0;
`endif

    assign half_we   = wren | flush_acc;
    assign half_data = wren ? i_wrdata : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        rddata_d = rddata_q;
        if (half_we) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rden) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            rddata_d = mem_q[rd_ptr_q];
        end
        cnt_d = cnt_q + {{DEPTH_W{1'b0}}, half_we} - {{(DEPTH_W-1){1'b0}}, rden, 1'b0};
    end

    always_ff @(posedge system_clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            rddata_q  <= '0;
            rdvalid_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            rddata_q  <= rddata_d;
            rdvalid_q <= rden;
        end
    end

    // Storage is not reset; each narrow write touches only its own half of the entry.
    always_ff @(posedge system_clk) begin
        if (half_we) begin
            if (wr_ptr_q[0]) begin
                mem_q[wr_ptr_q[DEPTH_W-1:1]][DATA_R-1:DATA_W] <= half_data;
            end else begin
                mem_q[wr_ptr_q[DEPTH_W-1:1]][DATA_W-1:0] <= half_data;
            end
        end
    end

    assign o_rddata  = rddata_q;
    assign o_rdvalid = rdvalid_q;

endmodule
